// File: rtl/debug_arb_pkg.sv
// Shared types and constants for the debug-port arbiter: FSM state encoding,
// the word returned on a timed-out read, and bus widths.
package debug_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/debug_arb_if.sv
// Level-request / pulse-ack link between the arbiter and the capture memory.
// The master holds debugreq and debugaddr; the slave answers with a single-cycle debugack.
interface debug_arb_if;
   import debug_arb_pkg::*;

   logic [ADDR_W-1:0] debugaddr;
   logic              debugreq;
   logic              debugack;
   logic [DATA_W-1:0] debugrdata;

   modport master (
      output debugaddr,
      output debugreq,
      input  debugack,
      input  debugrdata
   );

   modport slave (
      input  debugaddr,
      input  debugreq,
      output debugack,
      output debugrdata
   );

endinterface

// File: rtl/debug_arb_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping; purely combinational.
// Zero latency; no backpressure, pick_vld is simply low when no bit is set.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] pick_idx,
   output logic                    pick_vld
);
   localparam int IW = $clog2(NREQ);

   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      sum      = '0;
      idx      = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      // Walk from the farthest candidate back to ptr so the nearest one wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(NREQ)) begin
            sum = sum - (IW + 1)'(NREQ);
         end
         idx = sum[IW-1:0];
         if (req[idx]) begin
            pick_idx = idx;
            pick_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/debug_arb.sv
// Round-robin arbiter sharing one capture-memory debug port among NREQ requesters.
// debugreq rises 1 cycle after a request is seen idle; requesters wait (level req) until their ack.
module debug_arb
   import debug_arb_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 255,
   parameter int GAP     = 3
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NREQ-1:0]        req,
   input  logic [ADDR_W*NREQ-1:0] addr,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        err,
   output logic [DATA_W-1:0]      rdata,
   debug_arb_if.master            dport
);
   localparam int          IW  = $clog2(NREQ);
   localparam int          GW  = $clog2(GAP + 1);
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   logic [15:0]   timer;
   logic [GW-1:0] gcnt;
   logic [GW-1:0] wake;
   logic          wake_done;
   logic          do_grant;
   logic          do_done;
   logic          do_tmo;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req      (req),
      .ptr      (rr_ptr),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   // Holding off the first grant after reset guarantees the capture side a low period.
   assign wake_done = (wake == GW'(GAP));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      do_grant = 1'b0;
      do_done  = 1'b0;
      do_tmo   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_vld && wake_done) begin
               do_grant = 1'b1;
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A real answer beats a timeout landing in the same cycle.
            if (dport.debugack) begin
               do_done  = 1'b1;
               state_nx = ST_GAP;
            end else if (timer == TMO) begin
               do_done  = 1'b1;
               do_tmo   = 1'b1;
               state_nx = ST_GAP;
            end
         end
         ST_GAP: begin
            // The IDLE cycle that follows supplies the last low cycle of the gap.
            if (gcnt == GW'(GAP - 2)) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dport.debugaddr <= '0;
         dport.debugreq  <= 1'b0;
         ack             <= '0;
         err             <= '0;
         rdata           <= '0;
         rr_ptr          <= '0;
         grant           <= '0;
         timer           <= '0;
         gcnt            <= '0;
         wake            <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         if (!wake_done) begin
            wake <= wake + 1'b1;
         end
         if (state == ST_GAP) begin
            gcnt <= gcnt + 1'b1;
         end
         if (do_grant) begin
            grant           <= pick_idx;
            dport.debugaddr <= addr[{pick_idx, 4'b0000} +: ADDR_W];
            dport.debugreq  <= 1'b1;
            timer           <= '0;
         end else if (do_done) begin
            ack            <= NREQ'(1) << grant;
            err            <= do_tmo ? (NREQ'(1) << grant) : '0;
            rdata          <= do_tmo ? ERR_WORD : dport.debugrdata;
            dport.debugreq <= 1'b0;
            rr_ptr         <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
            gcnt           <= '0;
            timer          <= '0;
         end else if (state == ST_ISSUE) begin
            timer <= timer + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_debug_arb.sv
// Bench for debug_arb: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_debug_arb;
   localparam int NREQ    = 3;
   localparam int TIMEOUT = 255;
   localparam int GAP     = 3;
   localparam int AW      = 16 * NREQ;

   logic            clk = 1'b0;
   logic            resetn;
   logic [NREQ-1:0] req;
   logic [AW-1:0]   addr;
   logic [NREQ-1:0] ack;
   logic [NREQ-1:0] err;
   logic [31:0]     rdata;

   int total = 0;
   int bad   = 0;

   debug_arb_if dport();

   debug_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .addr   (addr),
      .ack    (ack),
      .err    (err),
      .rdata  (rdata),
      .dport  (dport)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   task automatic set_addr(input int i, input logic [15:0] a);
      addr = (addr & ~({{(AW-16){1'b0}}, 16'hFFFF} << (16 * i)))
           | ({{(AW-16){1'b0}}, a} << (16 * i));
   endtask

   task automatic wait_rise(input int limit, output int n);
      n = -1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (dport.debugreq === 1'b1) begin
            n = c;
            break;
         end
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if ((r & (NREQ'(1) << ((ptr + k) % NREQ))) != '0) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      req = '0;
      addr = '0;
      dport.debugack = 1'b0;
      dport.debugrdata = '0;
      repeat (3) @(negedge clk);
      total++; if (dport.debugreq !== 1'b0) begin bad++; $display("FAIL rst_debugreq got=%b want=0", dport.debugreq); end
      total++; if (dport.debugaddr !== 16'h0) begin bad++; $display("FAIL rst_debugaddr got=%h want=0000", dport.debugaddr); end
      total++; if (ack !== '0 || err !== '0) begin bad++; $display("FAIL rst_ack_err got=%b/%b want=000/000", ack, err); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=00000000", rdata); end
      resetn = 1'b1;
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n;
      int g;
      set_addr(0, 16'hA000);
      set_addr(1, 16'hA111);
      set_addr(2, 16'hA222);
      req = 3'b111;
      for (int t = 0; t < 4; t++) begin
         g = t % NREQ;
         wait_rise(20, n);
         total++; if (n !== ((t == 0) ? 1 : GAP)) begin bad++; $display("FAIL rr_low_cycles t=%0d got=%0d want=%0d", t, n, (t == 0) ? 1 : GAP); end
         total++; if (dport.debugaddr !== 16'(addr >> (16 * g))) begin bad++; $display("FAIL rr_grant t=%0d got=%h want=%h", t, dport.debugaddr, 16'(addr >> (16 * g))); end
         repeat (2) @(negedge clk);
         dport.debugack = 1'b1;
         dport.debugrdata = 32'hC0DE0000 + 32'(t);
         @(negedge clk);
         dport.debugack = 1'b0;
         total++; if (ack !== (NREQ'(1) << g)) begin bad++; $display("FAIL rr_ack t=%0d got=%b want=%b", t, ack, NREQ'(1) << g); end
         total++; if (rdata !== 32'hC0DE0000 + 32'(t)) begin bad++; $display("FAIL rr_rdata t=%0d got=%h want=%h", t, rdata, 32'hC0DE0000 + 32'(t)); end
      end
      req = '0;
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_single_read();
      int acks;
      int n;
      dport.debugack = 1'b1;
      dport.debugrdata = 32'hBAD00001;
      @(negedge clk);
      dport.debugack = 1'b0;
      @(negedge clk);
      total++; if (ack !== '0 || dport.debugreq !== 1'b0) begin bad++; $display("FAIL idle_spurious got ack=%b debugreq=%b want 000/0", ack, dport.debugreq); end
      set_addr(0, 16'h0010);
      req = 3'b001;
      wait_rise(8, n);
      total++; if (n !== 1) begin bad++; $display("FAIL sr_latency got=%0d want=1", n); end
      total++; if (dport.debugaddr !== 16'h0010) begin bad++; $display("FAIL sr_addr got=%h want=0010", dport.debugaddr); end
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack !== '0) acks++;
      end
      dport.debugack = 1'b1;
      dport.debugrdata = 32'h12345678;
      @(negedge clk);
      dport.debugack = 1'b0;
      req = '0;
      total++; if (acks !== 0) begin bad++; $display("FAIL sr_early_ack got=%0d want=0", acks); end
      total++; if (ack !== 3'b001 || err !== 3'b000) begin bad++; $display("FAIL sr_ack got=%b/%b want=001/000", ack, err); end
      total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL sr_rdata got=%h want=12345678", rdata); end
      total++; if (dport.debugreq !== 1'b0) begin bad++; $display("FAIL sr_req_drop got=%b want=0", dport.debugreq); end
      @(negedge clk);
      total++; if (ack !== '0) begin bad++; $display("FAIL sr_ack_pulse got=%b want=000", ack); end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      set_addr(1, 16'h0BAD);
      req = 3'b010;
      wait_rise(8, n);
      total++; if (n !== 1) begin bad++; $display("FAIL to_latency got=%0d want=1", n); end
      n = -1;
      for (int c = 1; c <= TIMEOUT + 10; c++) begin
         @(negedge clk);
         if (ack !== '0) begin
            n = c;
            break;
         end
      end
      req = '0;
      total++; if (n !== TIMEOUT + 1) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", n, TIMEOUT + 1); end
      total++; if (ack !== 3'b010 || err !== 3'b010) begin bad++; $display("FAIL to_ack_err got=%b/%b want=010/010", ack, err); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_rdata got=%h want=deadbeef", rdata); end
      @(negedge clk);
      total++; if (ack !== '0 || dport.debugreq !== 1'b0) begin bad++; $display("FAIL to_after got ack=%b debugreq=%b want 000/0", ack, dport.debugreq); end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_collision();
      int n;
      int acks;
      set_addr(2, 16'h0C01);
      req = 3'b100;
      wait_rise(8, n);
      total++; if (n !== 1) begin bad++; $display("FAIL col_latency got=%0d want=1", n); end
      acks = 0;
      repeat (TIMEOUT) begin
         @(negedge clk);
         if (ack !== '0) acks++;
      end
      dport.debugack = 1'b1;
      dport.debugrdata = 32'h5A5A1234;
      @(negedge clk);
      dport.debugack = 1'b0;
      req = '0;
      total++; if (acks !== 0) begin bad++; $display("FAIL col_early_ack got=%0d want=0", acks); end
      total++; if (ack !== 3'b100 || err !== 3'b000) begin bad++; $display("FAIL col_ack_err got=%b/%b want=100/000", ack, err); end
      total++; if (rdata !== 32'h5A5A1234) begin bad++; $display("FAIL col_rdata got=%h want=5a5a1234", rdata); end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_drop_mid();
      int n;
      int acks;
      int rises;
      set_addr(2, 16'h0D0D);
      req = 3'b100;
      wait_rise(8, n);
      total++; if (n !== 1) begin bad++; $display("FAIL drop_latency got=%0d want=1", n); end
      repeat (2) @(negedge clk);
      req = '0;
      repeat (3) @(negedge clk);
      dport.debugack = 1'b1;
      dport.debugrdata = 32'h0D0D0D0D;
      @(negedge clk);
      total++; if (ack !== 3'b100 || rdata !== 32'h0D0D0D0D) begin bad++; $display("FAIL drop_ack got=%b/%h want=100/0d0d0d0d", ack, rdata); end
      // debugack kept high through the gap and idle afterwards must be ignored
      acks = 0;
      rises = 0;
      repeat (10) begin
         @(negedge clk);
         if (ack !== '0) acks++;
         if (dport.debugreq !== 1'b0) rises++;
      end
      dport.debugack = 1'b0;
      total++; if (acks !== 0) begin bad++; $display("FAIL drop_extra_ack got=%0d want=0", acks); end
      total++; if (rises !== 0) begin bad++; $display("FAIL drop_regrant got=%0d want=0", rises); end
   endtask

   task automatic test_reset_mid_issue();
      int n;
      int acks;
      int early;
      set_addr(0, 16'h0E0E);
      req = 3'b001;
      wait_rise(8, n);
      total++; if (n !== 1) begin bad++; $display("FAIL rmi_latency got=%0d want=1", n); end
      repeat (10) @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      total++; if (dport.debugreq !== 1'b0) begin bad++; $display("FAIL rmi_async_drop got=%b want=0", dport.debugreq); end
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack !== '0) acks++;
      end
      resetn = 1'b1;
      early = 0;
      repeat (GAP) begin
         @(negedge clk);
         if (dport.debugreq !== 1'b0) early++;
         if (ack !== '0) acks++;
      end
      total++; if (acks !== 0) begin bad++; $display("FAIL rmi_lost_ack got=%0d want=0", acks); end
      total++; if (early !== 0) begin bad++; $display("FAIL rmi_early_grant got=%0d want=0", early); end
      @(negedge clk);
      total++; if (dport.debugreq !== 1'b1 || dport.debugaddr !== 16'h0E0E) begin bad++; $display("FAIL rmi_regrant got=%b/%h want=1/0e0e", dport.debugreq, dport.debugaddr); end
      dport.debugack = 1'b1;
      dport.debugrdata = 32'hE0E0E0E0;
      @(negedge clk);
      dport.debugack = 1'b0;
      req = '0;
      total++; if (ack !== 3'b001 || rdata !== 32'hE0E0E0E0) begin bad++; $display("FAIL rmi_ack got=%b/%h want=001/e0e0e0e0", ack, rdata); end
      repeat (GAP + 2) @(negedge clk);
   endtask

   task automatic test_random();
      logic [NREQ-1:0] r_drv;
      logic [NREQ-1:0] r_prev;
      logic [NREQ-1:0] oh;
      logic            dreq;
      logic            dreq_prev;
      logic            rise_exp;
      logic            exp_err;
      logic [31:0]     exp_data;
      int              low;
      int              cur;
      int              rr_m;
      int              ack_due;
      int              resp_cyc;
      int              g;
      int              d;
      int              ncomp;
      resetn = 1'b0;
      req = '0;
      dport.debugack = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (GAP + 2) @(negedge clk);
      r_drv = '0; r_prev = '0; dreq_prev = 1'b0; rise_exp = 1'b0;
      exp_err = 1'b0; exp_data = '0; low = GAP + 2; cur = -1; rr_m = 0;
      ack_due = -1; resp_cyc = -1; g = -1; ncomp = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         dreq = dport.debugreq;
         if (cur >= 0 && c == ack_due) begin
            oh = NREQ'(1) << cur;
            total++; if (ack !== oh) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, ack, oh); end
            total++; if (err !== (exp_err ? oh : '0)) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err, exp_err ? oh : '0); end
            total++; if (rdata !== exp_data) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rdata, exp_data); end
            rr_m = (cur + 1) % NREQ;
            ncomp++;
            if ($urandom_range(0, 1) == 0) r_drv = r_drv & ~oh;
            cur = -1;
         end else begin
            total++; if (ack !== '0 || err !== '0) begin bad++; $display("FAIL rnd_stray_ack c=%0d got=%b/%b want=000/000", c, ack, err); end
         end
         if (!dreq_prev) begin
            total++; if (dreq !== rise_exp) begin bad++; $display("FAIL rnd_rise c=%0d got=%b want=%b", c, dreq, rise_exp); end
            if (dreq && rise_exp) begin
               g = model_pick(r_prev, rr_m);
               total++; if (dport.debugaddr !== 16'(addr >> (16 * g))) begin bad++; $display("FAIL rnd_grant c=%0d got=%h want=%h", c, dport.debugaddr, 16'(addr >> (16 * g))); end
               cur = g;
               if ($urandom_range(0, 19) == 0) begin
                  resp_cyc = -1;
                  ack_due = c + TIMEOUT + 1;
                  exp_err = 1'b1;
                  exp_data = 32'hDEADBEEF;
               end else begin
                  d = $urandom_range(0, 6);
                  resp_cyc = c + d;
                  ack_due = c + d + 1;
                  exp_err = 1'b0;
                  exp_data = $urandom;
               end
            end
         end else begin
            total++; if (dreq !== (c != ack_due)) begin bad++; $display("FAIL rnd_hold c=%0d got=%b want=%b", c, dreq, c != ack_due); end
         end
         low = dreq ? 0 : (dreq_prev ? 1 : low + 1);
         if (c == resp_cyc) begin
            dport.debugack = 1'b1;
            dport.debugrdata = exp_data;
         end else if (!dreq && $urandom_range(0, 5) == 0) begin
            dport.debugack = 1'b1;
            dport.debugrdata = $urandom;
         end else begin
            dport.debugack = 1'b0;
         end
         for (int i = 0; i < NREQ; i++) begin
            if ((r_drv & (NREQ'(1) << i)) == '0 && $urandom_range(0, 3) == 0) begin
               set_addr(i, {4'(i), 12'($urandom)});
               r_drv = r_drv | (NREQ'(1) << i);
            end
         end
         req = r_drv;
         r_prev = r_drv;
         rise_exp = !dreq && low >= GAP && r_drv != '0;
         dreq_prev = dreq;
      end
      dport.debugack = 1'b0;
      req = '0;
      total++; if (ncomp < 50) begin bad++; $display("FAIL rnd_progress got=%0d want>=50", ncomp); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_timeout();
      test_collision();
      test_drop_mid();
      test_reset_mid_issue();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
